// File: rtl/stage_elastic_reg.sv
// rtl/stage_elastic_reg.sv - DEPTH-entry elastic pipeline register with flush and squash counter
module stage_elastic_reg #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  input  logic                         out_ready,
  output logic                         out_no_op,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [FCNT_WIDTH-1:0]        flush_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = ((FCNT_WIDTH > CW) ? FCNT_WIDTH : CW) + 1;
  localparam logic [SW-1:0] FSAT = SW'({FCNT_WIDTH{1'b1}});

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic                  offered;
  logic                  push;
  logic                  pop;
  logic [SW-1:0]         fsum;

  // in_ready depends on registered state only, so no ready path crosses the stage
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign out_no_op = ~out_valid;
  assign occupancy = count;

  assign offered = in_valid & in_ready;
  assign push    = offered & ~flush;
  assign pop     = out_valid & out_ready & ~flush;
  assign fsum    = SW'(flush_count) + SW'(count) + SW'(offered);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      flush_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // squashed beats saturate rather than wrap
      if (fsum > FSAT) begin
        flush_count <= '1;
      end else begin
        flush_count <= fsum[FCNT_WIDTH-1:0];
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
